// File: rtl/ipl_pkg.sv
// ipl_pkg: shared state encoding, constants and acknowledge-bit map for the IPL responder
package ipl_pkg;
    typedef enum logic [2:0] {IDLE, REQ, CYCLE, ACK, HOLD} state_t;
    localparam logic [2:0] IPL_NONE = 3'b111;
    function automatic logic [2:0] ack_bits(input logic [2:0] level);
        return level == 3'd3 ? 3'b001 :
               level == 3'd2 ? 3'b010 :
               level == 3'd1 ? 3'b100 : 3'b000;
    endfunction
endpackage

// File: rtl/ipl_sync.sv
// ipl_sync: two-flop synchroniser on nIPL, then accepts a value only after two equal samples
module ipl_sync
    import ipl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] nipl,
    output logic [2:0] level
);
    logic [2:0] s1, s2, prev, valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= IPL_NONE;
            s2    <= IPL_NONE;
            prev  <= IPL_NONE;
            valid <= IPL_NONE;
        end else begin
            s1   <= nipl;
            s2   <= s1;
            prev <= s2;
            if (s2 == prev) valid <= s2;
        end
    end
    assign level = ~valid;
endmodule

// File: rtl/ipl_iack.sv
// ipl_iack: CPU-side interrupt responder running the request/grant/done acknowledge handshake
module ipl_iack
    import ipl_pkg::*;
#(
    parameter int VEC_BASE = 24,
    parameter int HOLDOFF  = 4,
    parameter bit AUTO_ACK = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] nIPL,
    input  logic [2:0] IMASK,
    output logic       IACK_REQ,
    input  logic       IACK_GNT,
    input  logic       IACK_DONE,
    output logic [2:0] LEVEL,
    output logic [7:0] VECTOR,
    output logic       WR_ACK,
    output logic [2:0] ACK_BITS
);
    localparam int CW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [7:0] BASE = 8'(VEC_BASE);
    state_t state;
    logic [2:0] l, l_last;
    logic [CW-1:0] cnt;
    logic nmi, spur, nmi_set, pending, fire;
    ipl_sync u_sync (.clk(CLK), .rst(RESET), .nipl(nIPL), .level(l));
    // level 7 is non-maskable but only requests once per rising transition into 7
    assign nmi_set = l == 3'd7 && l_last != 3'd7;
    assign pending = l != 3'd0 && (l > IMASK || (l == 3'd7 && (nmi || nmi_set)));
    assign fire    = AUTO_ACK && !spur;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            IACK_REQ <= 1'b0;
            LEVEL    <= 3'd0;
            VECTOR   <= 8'd0;
            WR_ACK   <= 1'b0;
            ACK_BITS <= 3'd0;
            cnt      <= '0;
            nmi      <= 1'b0;
            spur     <= 1'b0;
            l_last   <= 3'd0;
        end else begin
            l_last   <= l;
            WR_ACK   <= 1'b0;
            ACK_BITS <= 3'd0;
            nmi      <= nmi | nmi_set;
            case (state)
                IDLE: if (pending && cnt == '0) begin
                    state    <= REQ;
                    LEVEL    <= l;
                    IACK_REQ <= 1'b1;
                end
                REQ: if (IACK_GNT) begin
                    state    <= CYCLE;
                    IACK_REQ <= 1'b0;
                    spur     <= !pending;
                    VECTOR   <= pending ? BASE + {5'b0, l} : BASE;
                    if (pending) LEVEL <= l;
                    if (pending && l == 3'd7) nmi <= 1'b0;
                end else if (!pending) begin
                    state    <= IDLE;
                    IACK_REQ <= 1'b0;
                end else begin
                    LEVEL <= l;
                end
                CYCLE: if (IACK_DONE) state <= ACK;
                ACK: begin
                    WR_ACK   <= fire;
                    ACK_BITS <= fire ? ack_bits(LEVEL) : 3'd0;
                    cnt      <= CW'(HOLDOFF);
                    state    <= HOLD;
                end
                HOLD: if (cnt == '0) state <= IDLE; else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ipl_iack.sv
// tb_ipl_iack: directed stimulus against a cycle-level behavioural model plus literal spot checks
module tb_ipl_iack;
    localparam int VB   = 24;
    localparam int HO   = 4;
    localparam bit AUTO = 1'b1;
    localparam int M_IDLE = 0, M_REQ = 1, M_CYC = 2, M_ACK = 3, M_HOLD = 4;

    logic CLK = 1'b0, RESET, IACK_GNT, IACK_DONE;
    logic [2:0] nIPL, IMASK;
    logic IACK_REQ, WR_ACK;
    logic [2:0] LEVEL, ACK_BITS;
    logic [7:0] VECTOR;

    ipl_iack #(.VEC_BASE(VB), .HOLDOFF(HO), .AUTO_ACK(AUTO)) dut (
        .CLK(CLK), .RESET(RESET), .nIPL(nIPL), .IMASK(IMASK),
        .IACK_REQ(IACK_REQ), .IACK_GNT(IACK_GNT), .IACK_DONE(IACK_DONE),
        .LEVEL(LEVEL), .VECTOR(VECTOR), .WR_ACK(WR_ACK), .ACK_BITS(ACK_BITS)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: L is the complement of the nIPL sample taken two edges ago, adopted only
    // when the sample three edges ago matched it; the rest follows the handshake rules.
    logic [2:0] smp[$];
    logic [2:0] lv;
    int cyc = 0, mode = M_IDLE, hold_end = 0, m_l = 0, m_lprev = 0, lvl;
    bit armed, m_spur, rise, pend, started = 0;
    logic e_req, e_wr;
    logic [2:0] e_level, e_bits;
    logic [7:0] e_vec;

    always @(posedge CLK) begin
        started = 1;
        if (RESET) begin
            smp = {3'b111, 3'b111, 3'b111};
            mode = M_IDLE; m_l = 0; m_lprev = 0; armed = 0; m_spur = 0;
            e_req = 0; e_level = 0; e_vec = 0; e_wr = 0; e_bits = 0;
        end else begin
            rise = m_l == 7 && m_lprev != 7;
            pend = m_l != 0 && (m_l > int'(IMASK) || (m_l == 7 && (armed || rise)));
            armed = armed || rise;
            e_wr = 0; e_bits = 0;
            if (mode == M_IDLE) begin
                if (pend) begin mode = M_REQ; e_req = 1; e_level = 3'(m_l); end
            end else if (mode == M_REQ) begin
                if (IACK_GNT) begin
                    e_req = 0; mode = M_CYC; m_spur = !pend;
                    if (pend) begin
                        e_level = 3'(m_l);
                        e_vec = 8'(VB + m_l);
                        if (m_l == 7) armed = 0;
                    end else e_vec = 8'(VB);
                end else if (!pend) begin
                    e_req = 0; mode = M_IDLE;
                end else e_level = 3'(m_l);
            end else if (mode == M_CYC) begin
                if (IACK_DONE) mode = M_ACK;
            end else if (mode == M_ACK) begin
                lvl = int'(e_level);
                if (AUTO && !m_spur) begin
                    e_wr = 1;
                    e_bits = (lvl >= 1 && lvl <= 3) ? 3'(4 >> (lvl - 1)) : 3'd0;
                end
                mode = M_HOLD; hold_end = cyc + HO + 1;
            end else if (cyc == hold_end) mode = M_IDLE;
            m_lprev = m_l;
            if (smp[0] == smp[1]) begin lv = ~smp[1]; m_l = int'(lv); end
            smp.push_back(nIPL);
            void'(smp.pop_front());
        end
        cyc++;
    end

    always @(negedge CLK) if (started) begin
        chk("m_iack_req", IACK_REQ, e_req);
        chk("m_level", LEVEL, e_level);
        chk("m_vector", VECTOR, e_vec);
        chk("m_wr_ack", WR_ACK, e_wr);
        chk("m_ack_bits", ACK_BITS, e_bits);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask
    task automatic gnt();
        IACK_GNT = 1; tick(1); IACK_GNT = 0;
    endtask
    task automatic done();
        IACK_DONE = 1; tick(1); IACK_DONE = 0;
    endtask

    initial begin
        RESET = 1; nIPL = 3'b111; IMASK = 0; IACK_GNT = 0; IACK_DONE = 0;
        tick(1);
        chk("rst_req", IACK_REQ, 0); chk("rst_level", LEVEL, 0); chk("rst_vec", VECTOR, 0);
        chk("rst_wr", WR_ACK, 0); chk("rst_bits", ACK_BITS, 0);
        tick(1); RESET = 0;
        // basic level-1 interrupt
        nIPL = 3'b110;
        tick(4); chk("t1_req_early", IACK_REQ, 0);
        tick(1); chk("t1_req", IACK_REQ, 1); chk("t1_level", LEVEL, 1);
        gnt(); chk("t1_vec", VECTOR, 25); chk("t1_req_drop", IACK_REQ, 0);
        nIPL = 3'b111;
        gnt(); chk("t1_gnt_ignored", VECTOR, 25);
        done(); chk("t1_wr_wait", WR_ACK, 0);
        tick(1); chk("t1_wr", WR_ACK, 1); chk("t1_bits", ACK_BITS, 3'b100);
        tick(1); chk("t1_wr_end", WR_ACK, 0);
        tick(10);
        // pre-emption by a higher level before the grant
        nIPL = 3'b110; tick(5); chk("t2_req", IACK_REQ, 1); chk("t2_level1", LEVEL, 1);
        nIPL = 3'b101; tick(5); chk("t2_level2", LEVEL, 2); chk("t2_req_hold", IACK_REQ, 1);
        gnt(); chk("t2_vec", VECTOR, 26);
        nIPL = 3'b111;
        done(); tick(1); chk("t2_wr", WR_ACK, 1); chk("t2_bits", ACK_BITS, 3'b010);
        tick(10);
        // masked level, then mask lowered
        IMASK = 2; nIPL = 3'b101; tick(8); chk("t3_masked", IACK_REQ, 0);
        IMASK = 1; tick(1); chk("t3_req", IACK_REQ, 1); chk("t3_level", LEVEL, 2);
        // pending falls in the same cycle as the grant: spurious
        nIPL = 3'b111; tick(4); chk("t4_req_held", IACK_REQ, 1);
        gnt(); chk("t4_vec", VECTOR, 24); chk("t4_req_drop", IACK_REQ, 0);
        done(); chk("t4_no_wr0", WR_ACK, 0);
        tick(1); chk("t4_no_wr1", WR_ACK, 0);
        tick(8); IMASK = 0;
        // level 7 with full mask: one request per transition into 7
        IMASK = 7; nIPL = 3'b000; tick(5); chk("t5_req", IACK_REQ, 1); chk("t5_level", LEVEL, 7);
        gnt(); chk("t5_vec", VECTOR, 31);
        done(); tick(1); chk("t5_wr", WR_ACK, 1); chk("t5_bits", ACK_BITS, 0);
        tick(20); chk("t5_no_rereq", IACK_REQ, 0);
        nIPL = 3'b111; tick(6); nIPL = 3'b000; tick(5); chk("t5_req2", IACK_REQ, 1);
        gnt(); nIPL = 3'b111; done(); tick(10); IMASK = 0;
        // reset during the acknowledge cycle
        nIPL = 3'b110; tick(5); chk("t6_req", IACK_REQ, 1);
        gnt(); tick(1);
        RESET = 1; tick(1);
        chk("t6_req", IACK_REQ, 0); chk("t6_level", LEVEL, 0); chk("t6_vec", VECTOR, 0);
        chk("t6_wr", WR_ACK, 0); chk("t6_bits", ACK_BITS, 0);
        RESET = 0;
        done(); chk("t6_no_wr0", WR_ACK, 0);
        tick(1); chk("t6_no_wr1", WR_ACK, 0);
        tick(2); chk("t6_req_early", IACK_REQ, 0);
        tick(1); chk("t6_rereq", IACK_REQ, 1); chk("t6_relevel", LEVEL, 1);
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ipl_iack.md
# ipl_iack

CPU-side interrupt responder: the receiving end of the IRQ encoder's IPL lines. It synchronises and validates the active-low priority level and compares it against the CPU status-register mask. It then runs the request/grant/done interrupt-acknowledge handshake with the CPU sequencer, supplies the autovector number, and, when AUTO_ACK is set, writes the matching acknowledge bit back to the IRQ encoder's WR_ACK/ACK_BITS inputs.

## Interface
- VEC_BASE, 24: autovector base; VECTOR = VEC_BASE + level; VEC_BASE alone is the spurious vector.
- HOLDOFF, 4: cycles after an acknowledge during which new requests are suppressed (covers encoder register plus sync latency).
- AUTO_ACK, 1: 1 = emit WR_ACK/ACK_BITS after each serviced level; 0 = never emit (software acknowledges).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- nIPL  in  3  active-low priority level (bit0 = IPL0), asynchronous to CLK; 3'b111 = no interrupt.
- IMASK  in  3  current CPU interrupt mask.
- IACK_REQ  out  1  interrupt pending request to the sequencer.
- IACK_GNT  in  1  one-cycle pulse: sequencer starts the acknowledge cycle.
- IACK_DONE  in  1  one-cycle pulse: vector fetched, exception entry complete.
- LEVEL  out  3  level being requested or serviced.
- VECTOR  out  8  vector number, valid from the cycle after GNT until the next GNT.
- WR_ACK  out  1  one-cycle acknowledge write strobe.
- ACK_BITS  out  3  acknowledge bits, valid with WR_ACK, 0 otherwise.

## Operation
- Input path: two-flop sync (reset to 3'b111). The validated level updates only when the synced value equals its previous-cycle copy (two equal samples). It is stored as L = ~validated nIPL.
- Pending: L != 0 and (L > IMASK, or L == 7 with the NMI-edge flag set). The NMI-edge flag sets when the validated L goes from <7 to 7. It clears when a level-7 request is granted.
- FSM states are IDLE, REQ, CYCLE, ACK and HOLD.
- IDLE: when pending and the holdoff counter is 0, go to REQ, set LEVEL = L and drive IACK_REQ high.
- REQ: LEVEL tracks L each cycle while pending, so a higher level pre-empts before the grant.
  - Pending falls with no GNT: drop IACK_REQ and return to IDLE.
  - GNT arrives: latch VECTOR, drop IACK_REQ and go to CYCLE.
    - If pending is true at GNT, VECTOR = VEC_BASE + LEVEL.
    - Otherwise VECTOR = VEC_BASE (spurious) and a spurious flag is set.
- CYCLE: wait for IACK_DONE, then go to ACK. GNT is ignored here.
- ACK (one cycle): if AUTO_ACK and not spurious, pulse WR_ACK with ACK_BITS from LEVEL: 3→3'b001, 2→3'b010, 1→3'b100, any other level→3'b000. Load the holdoff counter with HOLDOFF and go to HOLD.
- HOLD: decrement the counter; at 0 go to IDLE.
- Arithmetic: VECTOR = VEC_BASE[7:0] + {5'b0, LEVEL}, truncated to 8 bits.
- IACK_DONE outside CYCLE and IACK_GNT outside REQ are ignored.

## Timing
- Reset values: IACK_REQ 0, LEVEL 0, VECTOR 0, WR_ACK 0, ACK_BITS 0, state IDLE, holdoff 0, NMI flag 0, sync and validation registers 3'b111.
- nIPL stable from edge 0: L valid after edge 4; IACK_REQ high after edge 5.
- GNT sampled at edge k: IACK_REQ low and VECTOR valid after edge k.
- DONE at edge k: WR_ACK high for exactly the cycle after edge k+1.
- Pending deasserting and GNT in the same cycle: GNT wins and the spurious vector is used; no WR_ACK.
- Reset asserted in any state: next cycle all outputs hold reset values; no WR_ACK is emitted for an interrupted cycle.
- HOLDOFF = 0: HOLD lasts one cycle.

## Structure
- Package ipl_pkg holds:
  - FSM state enum (IDLE, REQ, CYCLE, ACK, HOLD);
  - function ack_bits(level) implementing the level→ACK_BITS map;
  - constant IPL_NONE = 3'b111.
- Sub-module ipl_sync: two-flop synchroniser plus two-sample validation; outputs the validated 3-bit level.

## Test plan
- nIPL = 3'b110 (L=1), IMASK = 0 → IACK_REQ at cycle 5; GNT → VECTOR = 25; DONE → WR_ACK with ACK_BITS = 3'b001? No: L=1 → ACK_BITS = 3'b100, one cycle.
- L=1 pending in REQ, nIPL switches to 3'b101 (L=2) before GNT → LEVEL = 2, VECTOR = 26, ACK_BITS = 3'b010.
- L=2, IMASK = 2 → IACK_REQ never asserts; IMASK drops to 1 → request within 1 cycle.
- nIPL returns to 3'b111 in the same cycle as GNT → VECTOR = 24, no WR_ACK, FSM returns to IDLE via HOLD.
- L=7 with IMASK = 7 → exactly one request per 0→7 transition; holding 7 after DONE gives no second request.
- RESET pulse during CYCLE → all outputs 0 next cycle, no WR_ACK; a still-held level re-requests 5 cycles after reset release.
